// File: rtl/ps2_key_tracker_if.sv
// rtl/ps2_key_tracker_if.sv - received scan-code byte stream (one strobe per byte)
interface ps2_key_tracker_if;
    logic [7:0] key_data;
    logic       key_pressed;

    modport master (output key_data, output key_pressed);
    modport slave  (input  key_data, input  key_pressed);
endinterface

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 set-2 make/break/E0 decoder with held levels for four keys
module ps2_key_tracker #(
    parameter logic [7:0] KEY0_CODE      = 8'h75,
    parameter logic [7:0] KEY1_CODE      = 8'h72,
    parameter logic [7:0] KEY2_CODE      = 8'h6B,
    parameter logic [7:0] KEY3_CODE      = 8'h74,
    parameter logic [3:0] KEY_EXT        = 4'b1111,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  logic                  clock,
    input  logic                  resetn,
    ps2_key_tracker_if.slave      kb,
    input  logic                  clear,
    output logic [3:0]            held,
    output logic [3:0]            press_pulse,
    output logic [7:0]            last_code,
    output logic                  last_break,
    output logic                  last_ext,
    output logic                  event_valid,
    output logic                  prefix_timeout
);
    localparam int              CW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     KEY_CODES = {KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    held_n;
    logic          ev, ev_ext, ev_brk, tmo;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        held_n  = held;
        ev      = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        tmo     = 1'b0;
        if (clear) begin
            state_n = IDLE;
            cnt_n   = '0;
            held_n  = '0;
        end else if (kb.key_pressed) begin
            cnt_n = '0;
            unique case (state)
                IDLE: begin
                    case (kb.key_data)
                        8'hE0: state_n = EXT;
                        8'hF0: state_n = BRK;
                        // Self-test, ack, resend, error and pause-prefix bytes carry no key
                        8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: ;
                        default: ev = 1'b1;
                    endcase
                end
                EXT: begin
                    if (kb.key_data == 8'hF0) begin
                        state_n = EXT_BRK;
                    end else if (kb.key_data != 8'hE0) begin
                        ev      = 1'b1;
                        ev_ext  = 1'b1;
                        state_n = IDLE;
                    end
                end
                BRK: begin
                    ev      = 1'b1;
                    ev_brk  = 1'b1;
                    state_n = IDLE;
                end
                EXT_BRK: begin
                    ev      = 1'b1;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
            if (ev) begin
                for (int i = 0; i < 4; i++) begin
                    if (kb.key_data == KEY_CODES[i*8 +: 8] && ev_ext == KEY_EXT[i])
                        held_n[i] = !ev_brk;
                end
            end
        end else if (state != IDLE) begin
            // A byte on the final count cycle takes the branch above, so it is never timed out
            if (cnt == CNT_LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
                tmo     = 1'b1;
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end else begin
            cnt_n = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            held           <= '0;
            press_pulse    <= '0;
            last_code      <= '0;
            last_break     <= 1'b0;
            last_ext       <= 1'b0;
            event_valid    <= 1'b0;
            prefix_timeout <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            held           <= held_n;
            press_pulse    <= held_n & ~held;
            event_valid    <= ev;
            prefix_timeout <= tmo;
            if (ev) begin
                last_code  <= kb.key_data;
                last_break <= ev_brk;
                last_ext   <= ev_ext;
            end
        end
    end
endmodule
